// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared defaults and next-pc source encoding for pc_gen
//
// Contents:
//   XLEN_DEFAULT, INSTR_BYTES_DEFAULT, RAS_DEPTH_DEFAULT - parameter defaults
//   next_src_e - which request selected the next fetch address
package pc_gen_pkg;

    localparam int unsigned XLEN_DEFAULT        = 32;
    localparam int unsigned INSTR_BYTES_DEFAULT = 4;
    localparam int unsigned RAS_DEPTH_DEFAULT   = 4;

    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_BRANCH,
        SRC_JUMP,
        SRC_CALL,
        SRC_RET,
        SRC_REDIRECT
    } next_src_e;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack used by pc_gen
//
// Only built when PC_GEN_RAS_EN is defined.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset (clears occupancy only)
//   push, push_data - write a return address; a full stack overwrites its oldest entry
//   pop             - discard the top entry (ignored when empty)
//   top             - most recently pushed live entry
//   empty           - no live entries
`ifdef PC_GEN_RAS_EN
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [XLEN-1:0]  mem [DEPTH];
    // ptr is the next write slot; when full it also points at the oldest
    // entry, so a push there naturally overwrites the oldest address.
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_W'(1);
            if (count != CNT_W'(DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (pop && (count != '0)) begin
            ptr   <= ptr - PTR_W'(1);
            count <= count - CNT_W'(1);
        end
    end

    // Contents survive reset; only occupancy decides what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    assign top   = mem[ptr - PTR_W'(1)];
    assign empty = (count == '0);

endmodule
`endif

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program-counter generator with optional return-address stack
//
// Optional feature macro: PC_GEN_RAS_EN (builds the return-address stack;
// without it call/ret behave as jumps to jump_target).
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   hold, fetch_ready            - stall / memory accept; pc advances when both allow
//   redirect, redirect_pc        - highest-priority redirect, honoured every edge
//   branch_taken, branch_offset  - pc-relative branch (signed offset, wraps)
//   jump, call, ret, jump_target - absolute jump, call (push), return (pop)
//   pc, pc_valid                 - fetch request
//   misaligned                   - pc not a multiple of INSTR_BYTES
//   ras_empty, ras_miss          - stack empty / one-cycle pulse on ret with empty stack
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     INSTR_BYTES  = INSTR_BYTES_DEFAULT,
    parameter int unsigned     RAS_DEPTH    = RAS_DEPTH_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hold,
    input  logic            fetch_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_offset,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic [XLEN-1:0] jump_target,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_miss
);

    logic            advance;
    next_src_e       src;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty_int;
    logic            ret_miss;

    assign advance = pc_valid & fetch_ready & ~hold;
    assign seq_pc  = pc + XLEN'(INSTR_BYTES);

    always_comb begin
        src = SRC_SEQ;
        if (redirect) begin
            src = SRC_REDIRECT;
        end else if (branch_taken) begin
            src = SRC_BRANCH;
`ifdef PC_GEN_RAS_EN
        end else if (call) begin
            // call wins over a simultaneous ret
            src = SRC_CALL;
        end else if (ret) begin
            src = SRC_RET;
        end else if (jump) begin
            src = SRC_JUMP;
`else
        end else if (call | ret | jump) begin
            src = SRC_JUMP;
`endif
        end
    end

    always_comb begin
        next_pc = seq_pc;
        case (src)
            SRC_REDIRECT: next_pc = redirect_pc;
            SRC_BRANCH:   next_pc = pc + branch_offset;
            SRC_CALL:     next_pc = jump_target;
            SRC_RET:      next_pc = ras_empty_int ? jump_target : ras_top;
            SRC_JUMP:     next_pc = jump_target;
            default:      next_pc = seq_pc;
        endcase
    end

    assign ret_miss = advance & (src == SRC_RET) & ras_empty_int;

`ifdef PC_GEN_RAS_EN
    logic ras_push;
    logic ras_pop;

    assign ras_push = advance & (src == SRC_CALL);
    assign ras_pop  = advance & (src == SRC_RET) & ~ras_empty_int;

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty_int)
    );
`else
    logic unused_ras_depth;

    assign ras_top          = '0;
    assign ras_empty_int    = 1'b1;
    assign unused_ras_depth = (RAS_DEPTH > 1);
`endif

    assign ras_empty  = ras_empty_int;
    assign misaligned = (pc % XLEN'(INSTR_BYTES)) != '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_VECTOR;
            pc_valid <= 1'b0;
            ras_miss <= 1'b0;
        end else begin
            ras_miss <= ret_miss;
            if (redirect) begin
                pc       <= redirect_pc;
                pc_valid <= 1'b1;
            end else if (!pc_valid) begin
                // first edge out of reset: start requesting RESET_VECTOR
                pc_valid <= 1'b1;
            end else if (advance) begin
                pc <= next_pc;
            end
        end
    end

endmodule
